reg_wb_arbiter: RTL and testbench

//   Write-side front end of the 32x32 register file. Accepts writeback requests

---
 rtl/reg_wb_arbiter.sv | 134 +++++++++++++
 tb/tb_reg_wb_arbiter.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Register-file writeback arbiter: one buffered entry each for the ALU and load paths, one RF write per cycle, read-port bypass.
// Latency: accept at edge E0, rf_w_en high after E1 when granted, RF commits at E2. Throughput is one write per cycle.
// Backpressure: ready = slot empty or slot granted this cycle. A load that loses STARVE_MAX times is forced through.
module reg_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              rf_w_en,
  output logic [ADDR_W-1:0] rf_w_addr,
  output logic [DATA_W-1:0] rf_w_data,
  input  logic [ADDR_W-1:0] byp_addr_a,
  input  logic [DATA_W-1:0] rf_data_a,
  output logic [DATA_W-1:0] byp_data_a,
  input  logic [ADDR_W-1:0] byp_addr_b,
  input  logic [DATA_W-1:0] rf_data_b,
  output logic [DATA_W-1:0] byp_data_b,
  output logic              pend_a,
  output logic              pend_b,
  output logic              ld_starved
);

  localparam int                CNT_W   = $clog2(STARVE_MAX + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(STARVE_MAX);

  logic              alu_full;
  logic [ADDR_W-1:0] alu_slot_addr;
  logic [DATA_W-1:0] alu_slot_data;
  logic              ld_full;
  logic [ADDR_W-1:0] ld_slot_addr;
  logic [DATA_W-1:0] ld_slot_data;
  logic [CNT_W-1:0]  starve_cnt;

  logic alu_gnt;
  logic ld_gnt;
  logic alu_acc;
  logic ld_acc;

  // The load only overrides the ALU once it has lost STARVE_MAX consecutive arbitrations.
  assign ld_starved = ld_full & (starve_cnt == CNT_MAX);
  assign alu_gnt    = alu_full & ~ld_starved;
  assign ld_gnt     = ld_full & (ld_starved | ~alu_full);

  // A granted slot drains on the same edge it refills, so it can take a new entry every cycle.
  // Readies are forced low while reset is asserted.
  assign alu_ready = rst_n & (~alu_full | alu_gnt);
  assign ld_ready  = rst_n & (~ld_full  | ld_gnt);
  assign alu_acc   = alu_valid & alu_ready;
  assign ld_acc    = ld_valid  & ld_ready;

  // ALU slot: load on a non-x0 accept, otherwise empty out when granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_full      <= 1'b0;
      alu_slot_addr <= '0;
      alu_slot_data <= '0;
    end else if (alu_acc && (alu_addr != '0)) begin
      alu_full      <= 1'b1;
      alu_slot_addr <= alu_addr;
      alu_slot_data <= alu_data;
    end else if (alu_gnt) begin
      alu_full      <= 1'b0;
    end
  end

  // Load slot: same policy as the ALU slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ld_full      <= 1'b0;
      ld_slot_addr <= '0;
      ld_slot_data <= '0;
    end else if (ld_acc && (ld_addr != '0)) begin
      ld_full      <= 1'b1;
      ld_slot_addr <= ld_addr;
      ld_slot_data <= ld_data;
    end else if (ld_gnt) begin
      ld_full      <= 1'b0;
    end
  end

  // Registered RF write port. Address and data hold their last values when no slot is granted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_w_en   <= 1'b0;
      rf_w_addr <= '0;
      rf_w_data <= '0;
    end else if (alu_gnt) begin
      rf_w_en   <= 1'b1;
      rf_w_addr <= alu_slot_addr;
      rf_w_data <= alu_slot_data;
    end else if (ld_gnt) begin
      rf_w_en   <= 1'b1;
      rf_w_addr <= ld_slot_addr;
      rf_w_data <= ld_slot_data;
    end else begin
      rf_w_en   <= 1'b0;
    end
  end

  // Counts the consecutive cycles a pending load loses arbitration. It saturates at STARVE_MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!ld_full || ld_gnt) begin
      starve_cnt <= '0;
    end else if (starve_cnt != CNT_MAX) begin
      starve_cnt <= starve_cnt + CNT_W'(1);
    end
  end

  // Bypass covers only the write the RF commits on the next edge. Data still in the slots is flagged through pend_* and is never forwarded.
  assign byp_data_a = (rf_w_en && (rf_w_addr == byp_addr_a) && (byp_addr_a != '0))
                      ? rf_w_data : rf_data_a;
  assign byp_data_b = (rf_w_en && (rf_w_addr == byp_addr_b) && (byp_addr_b != '0))
                      ? rf_w_data : rf_data_b;

  assign pend_a = (byp_addr_a != '0) &&
                  ((alu_full && (alu_slot_addr == byp_addr_a)) ||
                   (ld_full  && (ld_slot_addr  == byp_addr_a)));
  assign pend_b = (byp_addr_b != '0) &&
                  ((alu_full && (alu_slot_addr == byp_addr_b)) ||
                   (ld_full  && (ld_slot_addr  == byp_addr_b)));

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Testbench for reg_wb_arbiter. It applies a table of directed vectors, hand-written starvation and reset sequences, and a random stream.
// Every accepted non-x0 request is queued per source. Each RF write must match the head of one of those queues.
module tb_reg_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        alu_valid, ld_valid;
  logic        alu_ready, ld_ready;
  logic [4:0]  alu_addr, ld_addr, byp_addr_a, byp_addr_b, rf_w_addr;
  logic [31:0] alu_data, ld_data, rf_data_a, rf_data_b, rf_w_data;
  logic [31:0] byp_data_a, byp_data_b;
  logic        rf_w_en, pend_a, pend_b, ld_starved;

  int checks = 0;
  int errors = 0;

  reg_wb_arbiter #(.DATA_W(32), .ADDR_W(5), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_addr(alu_addr), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_data(ld_data),
    .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data),
    .byp_addr_a(byp_addr_a), .rf_data_a(rf_data_a), .byp_data_a(byp_data_a),
    .byp_addr_b(byp_addr_b), .rf_data_b(rf_data_b), .byp_data_b(byp_data_b),
    .pend_a(pend_a), .pend_b(pend_b), .ld_starved(ld_starved)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t alu_q[$];
  ent_t ld_q[$];
  logic acc_a = 1'b0;
  logic acc_l = 1'b0;

  // At each negedge, match the write the DUT issued on the previous edge, then queue the handshakes that complete on the next edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      alu_q.delete();
      ld_q.delete();
      acc_a = 1'b0;
      acc_l = 1'b0;
    end else begin
      if (rf_w_en) begin
        checks++;
        if (alu_q.size() > 0 && alu_q[0].a == rf_w_addr && alu_q[0].d == rf_w_data)
          void'(alu_q.pop_front());
        else if (ld_q.size() > 0 && ld_q[0].a == rf_w_addr && ld_q[0].d == rf_w_data)
          void'(ld_q.pop_front());
        else begin
          errors++;
          $display("FAIL sb_write: got x%0d=%h, matching neither queue head (alu %0d entries, ld %0d entries)",
                   rf_w_addr, rf_w_data, alu_q.size(), ld_q.size());
        end
      end
      acc_a = alu_valid & alu_ready;
      acc_l = ld_valid & ld_ready;
      if (acc_a && alu_addr != 5'd0) alu_q.push_back('{alu_addr, alu_data});
      if (acc_l && ld_addr != 5'd0)  ld_q.push_back('{ld_addr, ld_data});
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        av;   logic [4:0] aa;  logic [31:0] ad;
    logic        lv;   logic [4:0] la;  logic [31:0] ld;
    logic [4:0]  ba;
    logic        e_en; logic [4:0] e_addr; logic [31:0] e_data;
    logic        e_ardy; logic e_lrdy; logic e_pa; logic e_pb;
    logic [31:0] e_bypa; logic [31:0] e_bypb;
    logic        e_starv;
  } vec_t;

  localparam int NV = 12;
  localparam logic [31:0] RA = 32'h1111_1111;
  localparam logic [31:0] RB = 32'h2222_2222;
  vec_t tbl[NV];

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
    ld_valid  = 1'b0; ld_addr  = '0; ld_data  = '0;
  endtask

  initial begin
    // Byp B stays on x3 for the whole table. RF read data is a constant marker so any bypass shows up.
    tbl[0]  = '{0,0,0,            0,0,0,            5, 0,0,0,             1,1,0,0, RA,RB,0};
    tbl[1]  = '{1,5,32'hDEADBEEF, 0,0,0,            5, 0,0,0,             1,1,0,0, RA,RB,0};
    tbl[2]  = '{0,0,0,            0,0,0,            5, 0,0,0,             1,1,1,0, RA,RB,0};
    tbl[3]  = '{0,0,0,            0,0,0,            5, 1,5,32'hDEADBEEF,  1,1,0,0, 32'hDEADBEEF,RB,0};
    tbl[4]  = '{1,3,1,            1,4,2,            4, 0,5,32'hDEADBEEF,  1,1,0,0, RA,RB,0};
    tbl[5]  = '{0,0,0,            0,0,0,            4, 0,5,32'hDEADBEEF,  1,0,1,1, RA,RB,0};
    tbl[6]  = '{0,0,0,            0,0,0,            3, 1,3,1,             1,1,0,0, 1,1,0};
    tbl[7]  = '{0,0,0,            0,0,0,            4, 1,4,2,             1,1,0,0, 2,RB,0};
    tbl[8]  = '{1,0,32'hFFFF,     0,0,0,            0, 0,4,2,             1,1,0,0, RA,RB,0};
    tbl[9]  = '{0,0,0,            1,0,32'hFFFF,     0, 0,4,2,             1,1,0,0, RA,RB,0};
    tbl[10] = '{0,0,0,            0,0,0,            0, 0,4,2,             1,1,0,0, RA,RB,0};
    tbl[11] = '{0,0,0,            0,0,0,            0, 0,4,2,             1,1,0,0, RA,RB,0};

    idle_inputs();
    byp_addr_a = '0; byp_addr_b = 5'd3; rf_data_a = RA; rf_data_b = RB;

    // Test 1: reset state, with readies held low during reset.
    rst_n = 1'b0;
    #22;
    chk("rst_en",    32'(rf_w_en),    32'd0);
    chk("rst_addr",  32'(rf_w_addr),  32'd0);
    chk("rst_data",  rf_w_data,       32'd0);
    chk("rst_ardy",  32'(alu_ready),  32'd0);
    chk("rst_lrdy",  32'(ld_ready),   32'd0);
    chk("rst_starv", 32'(ld_starved), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rel_ardy", 32'(alu_ready), 32'd1);
    chk("rel_lrdy", 32'(ld_ready),  32'd1);
    step();

    // Tests 2, 3 and 5: ALU latency and bypass, simultaneous ALU/LD requests, x0 writes.
    for (int i = 0; i < NV; i++) begin
      alu_valid = tbl[i].av; alu_addr = tbl[i].aa; alu_data = tbl[i].ad;
      ld_valid  = tbl[i].lv; ld_addr  = tbl[i].la; ld_data  = tbl[i].ld;
      byp_addr_a = tbl[i].ba;
      @(negedge clk);
      chk($sformatf("r%0d_en", i),    32'(rf_w_en),    32'(tbl[i].e_en));
      chk($sformatf("r%0d_addr", i),  32'(rf_w_addr),  32'(tbl[i].e_addr));
      chk($sformatf("r%0d_data", i),  rf_w_data,       tbl[i].e_data);
      chk($sformatf("r%0d_ardy", i),  32'(alu_ready),  32'(tbl[i].e_ardy));
      chk($sformatf("r%0d_lrdy", i),  32'(ld_ready),   32'(tbl[i].e_lrdy));
      chk($sformatf("r%0d_pa", i),    32'(pend_a),     32'(tbl[i].e_pa));
      chk($sformatf("r%0d_pb", i),    32'(pend_b),     32'(tbl[i].e_pb));
      chk($sformatf("r%0d_bypa", i),  byp_data_a,      tbl[i].e_bypa);
      chk($sformatf("r%0d_bypb", i),  byp_data_b,      tbl[i].e_bypb);
      chk($sformatf("r%0d_starv", i), 32'(ld_starved), 32'(tbl[i].e_starv));
      step();
    end

    // Test 4: the ALU requests every cycle while LD x7=9 waits. LD loses 4 times and wins on the 5th.
    alu_valid = 1'b1; alu_addr = 5'd10; alu_data = 32'd100;
    ld_valid  = 1'b1; ld_addr  = 5'd7;  ld_data  = 32'd9;
    step();
    ld_valid = 1'b0;
    alu_addr = 5'd11; alu_data = 32'd101;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      chk($sformatf("st%0d_starv", k), 32'(ld_starved), (k == 5) ? 32'd1 : 32'd0);
      chk($sformatf("st%0d_ardy", k),  32'(alu_ready),  (k == 5) ? 32'd0 : 32'd1);
      chk($sformatf("st%0d_lrdy", k),  32'(ld_ready),   (k == 5) ? 32'd1 : 32'd0);
      step();
      if (acc_a) begin
        alu_addr = alu_addr + 5'd1;
        alu_data = alu_data + 32'd1;
      end
    end
    alu_valid = 1'b0;
    @(negedge clk);
    chk("st_ld_en",   32'(rf_w_en),   32'd1);
    chk("st_ld_addr", 32'(rf_w_addr), 32'd7);
    chk("st_ld_data", rf_w_data,      32'd9);
    step();
    repeat (4) step();

    // Test 6: assert reset while both slots are full and a write is on the port.
    alu_valid = 1'b1; alu_addr = 5'd20; alu_data = 32'hAA;
    ld_valid  = 1'b1; ld_addr  = 5'd21; ld_data  = 32'hBB;
    step();
    idle_inputs();
    step();
    chk("r6_pre_en", 32'(rf_w_en), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("r6_en_drop", 32'(rf_w_en),   32'd0);
    chk("r6_addr",    32'(rf_w_addr), 32'd0);
    chk("r6_ardy",    32'(alu_ready), 32'd0);
    chk("r6_lrdy",    32'(ld_ready),  32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    byp_addr_a = 5'd21;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("r6_post%0d_en", k), 32'(rf_w_en), 32'd0);
      chk($sformatf("r6_post%0d_pa", k), 32'(pend_a),  32'd0);
    end
    step();

    // Random stream: each valid is held until it is accepted. The scoreboard checks source order and data.
    for (int c = 0; c < 300; c++) begin
      logic [31:0] r;
      if (!alu_valid || acc_a) begin
        r = $urandom();
        alu_valid = ($urandom_range(0, 9) < 7);
        alu_addr  = 5'($urandom_range(0, 31));
        alu_data  = {1'b0, r[30:0]};
      end
      if (!ld_valid || acc_l) begin
        r = $urandom();
        ld_valid = ($urandom_range(0, 9) < 5);
        ld_addr  = 5'($urandom_range(0, 31));
        ld_data  = {1'b1, r[30:0]};
      end
      byp_addr_a = 5'($urandom_range(0, 31));
      step();
    end
    idle_inputs();
    for (int c = 0; c < 20 && (alu_q.size() + ld_q.size()) != 0; c++) step();
    repeat (2) step();
    chk("drain_alu_q", 32'(alu_q.size()), 32'd0);
    chk("drain_ld_q",  32'(ld_q.size()),  32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
